uio_bus_arbiter: RTL and testbench
==================================

Name: uio_bus_arbiter

Overview:
Round-robin arbiter that shares the 8-bit bidirectional uio pad bus of the tt_um_top_joms top among NUM_REQ internal requesters. Each requester wins a burst of beats and either drives the pads (write) or samples them (read). Bus ownership changes are separated by dead turnaround cycles with all pads released. It sits directly behind the top-level uio_in/uio_out/uio_oe ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 8, maximum beats per grant (1..16)
TURN_CYCLES, 1, dead cycles with uio_oe=0 before each grant (0..3)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; low forces bus release
req  in  NUM_REQ  per-requester request, held high for the whole burst
dir  in  NUM_REQ  per-requester direction: 1=drive pads, 0=sample pads
last  in  NUM_REQ  marks the final beat of the requester's burst
wdata  in  NUM_REQ*8  per-requester write byte; slice i = bits [8i+7:8i]
gnt  out  NUM_REQ  one-hot grant; a beat transfers on any cycle with gnt[i]&req[i]
rdata  out  8  registered sample of uio_in from the last read beat
rvalid  out  1  one-cycle pulse: rdata holds a new read beat
rvalid_id  out  clog2(NUM_REQ)  owner index of the read beat shown on rdata
uio_in  in  8  pad input bus
uio_out  out  8  pad output bus
uio_oe  out  8  pad output enable, 0xFF or 0x00 only
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, uio_oe=0x00, uio_out=0x00, rdata=0x00, rvalid=0, rvalid_id=0, rr pointer=0, beat count=0, busy=0. Outputs take these values immediately, with no clock edge required.
- States: IDLE, TURN, OWN.
- IDLE: when ena=1 and any req bit is set, a round-robin pick runs from the pointer (pointer index has highest priority, ascending with wrap). The pick latches owner and dir_q=dir[owner]. Next state is TURN, or OWN if TURN_CYCLES=0.
- TURN: lasts exactly TURN_CYCLES cycles. uio_oe=0x00 and gnt=0 throughout. Then OWN.
- OWN:
  - gnt[owner]=1, derived from registered state only.
  - uio_oe = dir_q ? 0xFF : 0x00.
  - uio_out = wdata[owner] while dir_q=1, otherwise 0x00.
- Read beat: uio_in is registered into rdata at the end of the beat. rvalid=1 and rvalid_id=owner on the following cycle.
- Beat count increments on each transferred beat.
- OWN exits after a transfer cycle if last[owner]=1 or count reaches MAX_BURST-1.
- OWN also exits on a cycle with req[owner]=0. That cycle is not a beat: no transfer and no rvalid.
- On exit:
  - pointer <= (owner+1) mod NUM_REQ; count cleared.
  - If ena=1 and any req is pending, re-arbitrate with the new pointer in the same cycle and go to TURN/OWN. The previous owner is eligible at lowest priority.
  - Otherwise go to IDLE.
- dir, last and wdata are sampled only when req is high; a change of dir mid-burst is ignored (dir_q holds).
- ena=0 in any state: next state IDLE, uio_oe=0x00 on the next cycle, pointer unchanged, count cleared.
- gnt is never asserted in IDLE or TURN.
- Never more than one gnt bit set at a time.
- uio_oe is never 0xFF in the cycle after an owner change.

Decomposition:
- Package uio_arb_pkg: state enum (IDLE/TURN/OWN), BUS_W=8, OE_DRIVE=8'hFF, OE_RELEASE=8'h00.
- Sub-module rr_pick: combinational; inputs req vector and pointer; outputs valid and index.
- The FSM, counters and bus muxing stay in uio_bus_arbiter.

Test Plan:
1. rst_n=0 with stray req/ena=1 -> gnt=0, uio_oe=00, uio_out=00, rvalid=0, busy=0. Release reset: first grant goes to req0 when all req bits are set.
2. req0, dir0=1, wdata0=0xA5, last on 3rd beat, TURN_CYCLES=1 -> 1 TURN cycle with oe=00, then gnt0 for 3 cycles with uio_oe=FF and uio_out=A5, then IDLE with oe=00 and busy=0.
3. req0 and req2 held, last never set, MAX_BURST=8 -> gnt0 for 8 beats, 1 TURN, gnt2 for 8 beats, 1 TURN, gnt0 again. Never overlapping.
4. req1, dir1=0, uio_in=0x3C, last on beat 1 -> uio_oe=00 during OWN, next cycle rdata=3C with rvalid=1 and rvalid_id=1 for one cycle.
5. req3 drops after 2 beats -> no beat that cycle, exit, pointer=0. Separately, ena=0 mid-burst -> next cycle IDLE with oe=00 and gnt=0.
6. rst_n asserted mid-write burst between clock edges -> uio_oe=00 and gnt=0 immediately without a clock edge. After release, arbitration restarts from pointer 0.

Source files
------------

// File: rtl/uio_bus_arbiter_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uio_arb_pkg;

    localparam int         BUS_W      = 8;
    localparam logic [7:0] OE_DRIVE   = 8'hFF;
    localparam logic [7:0] OE_RELEASE = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } state_t;

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Requester handshake plus uio pad bundle shared by the arbiter and its users.
// Latency: none (wires only).
// Backpressure: a requester holds req until it sees its gnt bit for the whole burst.
interface uio_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uio_arb_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       dir;
    logic [NUM_REQ-1:0]       last;
    logic [NUM_REQ*BUS_W-1:0] wdata;
    logic [NUM_REQ-1:0]       gnt;
    logic [BUS_W-1:0]         rdata;
    logic                     rvalid;
    logic [ID_W-1:0]          rvalid_id;
    logic [BUS_W-1:0]         uio_in;
    logic [BUS_W-1:0]         uio_out;
    logic [BUS_W-1:0]         uio_oe;
    logic                     busy;

    // Requesters and pads side.
    modport master (
        output req, dir, last, wdata, uio_in,
        input  gnt, rdata, rvalid, rvalid_id, uio_out, uio_oe, busy
    );

    // Arbiter side.
    modport slave (
        input  req, dir, last, wdata, uio_in,
        output gnt, rdata, rvalid, rvalid_id, uio_out, uio_oe, busy
    );

endinterface

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
// Latency: combinational.
// Backpressure: none; valid low when no request is set.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);

    logic [NUM_REQ-1:0] rot;

    // Rotate so bit k is the request at priority rank k (rank 0 = ptr).
    assign rot = NUM_REQ'({req, req} >> ptr);

    // Walk from lowest to highest rank so the highest-ranked hit is kept.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                idx   = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the uio pads: dead turnaround cycles, then a burst of beats.
// Latency: TURN_CYCLES+1 cycles from request to grant; read data one cycle after its beat.
// Backpressure: a beat moves only when gnt&req; dropping req or ena ends the burst.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    uio_bus_arbiter_if.slave bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = 4;
    localparam int TC_W  = 2;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic             dir_q, dir_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TC_W-1:0]  turn_q, turn_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic [ID_W-1:0]  rid_q, rid_d;

    logic             own;
    logic             beat;
    logic             grant_now;
    logic [ID_W-1:0]  next_ptr;
    logic [ID_W-1:0]  pick_ptr;
    logic             pick_valid;
    logic [ID_W-1:0]  pick_idx;
    logic [BUS_W-1:0] wsel;

    assign own      = (state_q == OWN);
    assign beat     = own && bus.req[owner_q];
    assign next_ptr = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    // On burst exit the search starts just past the old owner, so it ranks last.
    assign pick_ptr = own ? next_ptr : ptr_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state logic: arbitration, turnaround timing, burst accounting and read capture.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        dir_d     = dir_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        turn_d    = turn_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        rid_d     = rid_q;
        grant_now = 1'b0;

        case (state_q)
            IDLE: grant_now = pick_valid;
            TURN: begin
                if (int'(turn_q) >= TURN_CYCLES - 1) begin
                    state_d = OWN;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            OWN: begin
                if (beat && !dir_q) begin
                    rdata_d  = bus.uio_in;
                    rvalid_d = 1'b1;
                    rid_d    = owner_q;
                end
                if (!bus.req[owner_q] || bus.last[owner_q] ||
                    int'(cnt_q) == MAX_BURST - 1) begin
                    ptr_d     = next_ptr;
                    cnt_d     = '0;
                    state_d   = IDLE;
                    grant_now = pick_valid;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_now) begin
            owner_d = pick_idx;
            dir_d   = bus.dir[pick_idx];
            turn_d  = '0;
            state_d = (TURN_CYCLES == 0) ? OWN : TURN;
        end

        // Disable wins over everything: release the bus, keep the pointer.
        if (!ena) begin
            state_d = IDLE;
            cnt_d   = '0;
            turn_d  = '0;
            ptr_d   = ptr_q;
        end
    end

    // State register with asynchronous reset to an idle, released bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            dir_q    <= 1'b0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            turn_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            dir_q    <= dir_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            turn_q   <= turn_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
        end
    end

    // Select the owner's write byte.
    always_comb begin
        wsel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == ID_W'(i)) begin
                wsel = bus.wdata[i*BUS_W +: BUS_W];
            end
        end
    end

    assign bus.gnt       = own ? (NUM_REQ'(1) << owner_q) : '0;
    assign bus.uio_oe    = (own && dir_q) ? OE_DRIVE : OE_RELEASE;
    assign bus.uio_out   = (own && dir_q) ? wsel : '0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rvalid_id = rid_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: vector table, directed corners, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uio_bus_arbiter;

    localparam int N  = 4;
    localparam int MB = 8;
    localparam int TC = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    uio_bus_arbiter_if #(.NUM_REQ(N)) bus ();

    uio_bus_arbiter #(
        .NUM_REQ     (N),
        .MAX_BURST   (MB),
        .TURN_CYCLES (TC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req, dir, last;
        logic [7:0] wd, ui;
        logic [3:0] gnt;
        logic [7:0] oe, out;
        logic       busy, rv;
        logic [7:0] rd;
        logic [1:0] rid;
    } vec_t;

    vec_t tbl[13];

    // Reference model state: owner -1 means nobody holds or waits for the bus.
    int         m_own, m_gap, m_beats, m_ptr;
    bit         m_dir, m_rv;
    logic [7:0] m_rd;
    int         m_rid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] d, input logic [3:0] l,
                         input logic [7:0] wd, input logic [7:0] ui, input logic e);
        bus.req    = r;
        bus.dir    = d;
        bus.last   = l;
        bus.wdata  = {wd ^ 8'h30, wd ^ 8'h20, wd ^ 8'h10, wd};
        bus.uio_in = ui;
        ena        = e;
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int choose(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1; m_gap = 0; m_beats = 0; m_ptr = 0;
        m_dir = 1'b0; m_rv = 1'b0; m_rd = 8'h00; m_rid = 0;
    endtask

    task automatic model_grant(input int p);
        m_own = choose(bus.req, p);
        if (m_own >= 0) begin
            m_dir = bus.dir[m_own];
            m_gap = TC;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit done;
        m_rv = 1'b0;
        if (m_own >= 0 && m_gap == 0) begin
            if (bus.req[m_own] && !m_dir) begin
                m_rd  = bus.uio_in;
                m_rv  = 1'b1;
                m_rid = m_own;
            end
            done = !bus.req[m_own] || bus.last[m_own] || (m_beats + 1 == MB);
            if (!ena) begin
                m_own = -1; m_beats = 0;
            end else if (done) begin
                m_ptr = (m_own + 1) % N;
                m_beats = 0;
                model_grant(m_ptr);
            end else begin
                m_beats++;
            end
        end else if (m_own >= 0) begin
            if (!ena) m_own = -1;
            else m_gap--;
        end else if (ena) begin
            model_grant(m_ptr);
        end
    endtask

    task automatic model_check(input int cyc);
        bit         owning;
        logic [7:0] exp_out;
        owning  = (m_own >= 0) && (m_gap == 0);
        exp_out = (owning && m_dir) ? bus.wdata[m_own*8 +: 8] : 8'h00;
        chk($sformatf("rnd%0d_gnt", cyc), bus.gnt, owning ? (32'd1 << m_own) : 32'd0);
        chk($sformatf("rnd%0d_oe", cyc), bus.uio_oe, (owning && m_dir) ? 32'hFF : 32'h00);
        chk($sformatf("rnd%0d_out", cyc), bus.uio_out, exp_out);
        chk($sformatf("rnd%0d_busy", cyc), bus.busy, m_own >= 0);
        chk($sformatf("rnd%0d_rv", cyc), bus.rvalid, m_rv);
        chk($sformatf("rnd%0d_rd", cyc), bus.rdata, m_rd);
        chk($sformatf("rnd%0d_rid", cyc), bus.rvalid_id, m_rid);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_g;
        logic [3:0] r;

        // Single write burst, re-grant of the previous owner, then a read burst.
        //           req   dir   last  wd     ui     gnt   oe     out    bsy   rv    rd     rid
        tbl[0]  = '{4'h1, 4'h1, 4'h0, 8'hA5, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{4'h1, 4'h1, 4'h0, 8'hA5, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[2]  = '{4'h1, 4'h1, 4'h0, 8'hA5, 8'h00, 4'h1, 8'hFF, 8'hA5, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[3]  = '{4'h1, 4'h1, 4'h0, 8'hA5, 8'h00, 4'h1, 8'hFF, 8'hA5, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[4]  = '{4'h1, 4'h1, 4'h1, 8'hA5, 8'h00, 4'h1, 8'hFF, 8'hA5, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[5]  = '{4'h0, 4'h0, 4'h0, 8'hA5, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[6]  = '{4'h0, 4'h0, 4'h0, 8'hA5, 8'h00, 4'h1, 8'hFF, 8'hA5, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[7]  = '{4'h2, 4'h0, 4'h2, 8'hA5, 8'h3C, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[8]  = '{4'h2, 4'h0, 4'h2, 8'hA5, 8'h3C, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[9]  = '{4'h2, 4'h0, 4'h2, 8'hA5, 8'h3C, 4'h2, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[10] = '{4'h0, 4'h0, 4'h0, 8'hA5, 8'h55, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h3C, 2'd1};
        tbl[11] = '{4'h0, 4'h0, 4'h0, 8'hA5, 8'h55, 4'h2, 8'h00, 8'h00, 1'b1, 1'b0, 8'h3C, 2'd1};
        tbl[12] = '{4'h0, 4'h0, 4'h0, 8'hA5, 8'h55, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h3C, 2'd1};

        // Reset with stray requests and enable: outputs idle before any clock edge.
        rst_n = 1'b0;
        drive(4'hF, 4'hF, 4'h0, 8'h5A, 8'h00, 1'b1);
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_oe", bus.uio_oe, 8'h00);
        chk("rst_out", bus.uio_out, 8'h00);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdata", bus.rdata, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_idle_gnt", bus.gnt, 0);
        @(negedge clk); #1;
        chk("rel_turn_gnt", bus.gnt, 0);
        chk("rel_turn_busy", bus.busy, 1);
        @(negedge clk); #1;
        chk("rel_first_gnt", bus.gnt, 4'h1);

        // Vector table.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].req, tbl[i].dir, tbl[i].last, tbl[i].wd, tbl[i].ui, 1'b1);
            #1;
            chk($sformatf("tbl%0d_gnt", i), bus.gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_oe", i), bus.uio_oe, tbl[i].oe);
            chk($sformatf("tbl%0d_out", i), bus.uio_out, tbl[i].out);
            chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
            chk($sformatf("tbl%0d_rv", i), bus.rvalid, tbl[i].rv);
            chk($sformatf("tbl%0d_rd", i), bus.rdata, tbl[i].rd);
            chk($sformatf("tbl%0d_rid", i), bus.rvalid_id, tbl[i].rid);
        end

        // Two endless requesters alternate in maximal bursts separated by one dead cycle.
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) @(negedge clk);
            drive(4'h5, 4'h5, 4'h0, 8'h11, 8'h00, 1'b1);
            #1;
            if (k == 0 || (k - 1) % 9 == 0) exp_g = 0;
            else exp_g = (((k - 1) / 9) % 2 == 0) ? 1 : 4;
            chk($sformatf("alt%0d_gnt", k), bus.gnt, exp_g);
        end

        // Requester 3 abandons its burst after two beats.
        do_reset();
        drive(4'h8, 4'h8, 4'h0, 8'h77, 8'h00, 1'b1);
        @(negedge clk); @(negedge clk); #1;
        chk("drop_beat1_gnt", bus.gnt, 4'h8);
        @(negedge clk); #1;
        chk("drop_beat2_gnt", bus.gnt, 4'h8);
        @(negedge clk);
        drive(4'h0, 4'h8, 4'h0, 8'h77, 8'h00, 1'b1);
        #1;
        chk("drop_cycle_rv", bus.rvalid, 0);
        @(negedge clk);
        drive(4'h9, 4'h9, 4'h0, 8'h77, 8'h00, 1'b1);
        #1;
        chk("drop_idle_busy", bus.busy, 0);
        chk("drop_idle_gnt", bus.gnt, 0);
        @(negedge clk); @(negedge clk); #1;
        chk("drop_wrap_gnt", bus.gnt, 4'h1);
        chk("drop_wrap_oe", bus.uio_oe, 8'hFF);

        // Disable mid-burst.
        @(negedge clk);
        drive(4'h9, 4'h9, 4'h0, 8'h77, 8'h00, 1'b0);
        #1;
        chk("ena_low_gnt_same", bus.gnt, 4'h1);
        @(negedge clk);
        drive(4'h1, 4'h1, 4'h1, 8'h66, 8'h00, 1'b1);
        #1;
        chk("ena_low_gnt", bus.gnt, 0);
        chk("ena_low_oe", bus.uio_oe, 8'h00);
        chk("ena_low_busy", bus.busy, 0);

        // One-beat burst moves the pointer to 1, then async reset in the middle of a write.
        @(negedge clk); @(negedge clk); #1;
        chk("arst_pre_gnt", bus.gnt, 4'h1);
        @(negedge clk);
        drive(4'h1, 4'h1, 4'h0, 8'h66, 8'h00, 1'b1);
        @(negedge clk); @(negedge clk); #1;
        chk("arst_own_oe", bus.uio_oe, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", bus.gnt, 0);
        chk("arst_oe", bus.uio_oe, 8'h00);
        chk("arst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'hF, 4'h0, 4'h0, 8'h66, 8'h00, 1'b1);
        @(negedge clk); @(negedge clk); #1;
        chk("arst_restart_gnt", bus.gnt, 4'h1);

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        r = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(9) == 0) r[i] = ~r[i];
            end
            bus.req    = r;
            bus.dir    = 4'($urandom);
            for (int i = 0; i < N; i++) bus.last[i] = ($urandom_range(5) == 0);
            bus.wdata  = $urandom;
            bus.uio_in = 8'($urandom);
            ena        = ($urandom_range(39) != 0);
            #1;
            model_check(c);
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
